// File: rtl/i2c_slave_core.sv
// i2c_slave_core: I2C slave with an internal byte-wide register file.
//   Ports: clk/nReset          system clock, async active-low reset
//          scl_i/sda_i         raw bus inputs (oversampled, synchronised, filtered)
//          sda_o/sda_oen       open-drain SDA driver (sda_o fixed 0, oen active-low)
//          host_adr/host_dat   combinational host read-back of the register file
//          wr_stb/wr_adr/wr_dat  one-clk strobe per byte written from the bus
//          start_det/stop_det  one-clk bus condition strobes
//          busy                high between START and STOP
// Protocol: dev-addr byte, mem-addr byte, then auto-incrementing data with wrap.

// Per-line input conditioner: 2-FF synchroniser followed by a stability
// counter. Output follows the input only after FILTER consecutive differing
// samples, so latency is 2+FILTER clks and shorter pulses vanish.
module i2c_slave_filt #(
  parameter int FILTER = 3
) (
  input  logic clk,
  input  logic nReset,
  input  logic din,
  output logic dout
);
  logic [1:0] sync;
  logic [3:0] cnt;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sync <= 2'b11;
      cnt  <= '0;
      dout <= 1'b1;
    end else begin
      sync <= {sync[0], din};
      if (sync[1] == dout)                 cnt <= '0;
      else if (cnt == 4'(FILTER - 1)) begin
        dout <= sync[1];
        cnt  <= '0;
      end else                             cnt <= cnt + 4'd1;
    end
  end
endmodule

module i2c_slave_core #(
  parameter logic [6:0] I2C_ADR = 7'h10,
  parameter int         MEM_AW  = 4,
  parameter int         FILTER  = 3
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_o,
  output logic              sda_oen,
  input  logic [MEM_AW-1:0] host_adr,
  output logic [7:0]        host_dat,
  output logic              wr_stb,
  output logic [MEM_AW-1:0] wr_adr,
  output logic [7:0]        wr_dat,
  output logic              start_det,
  output logic              stop_det,
  output logic              busy
);
  localparam int MEM_DEPTH = 1 << MEM_AW;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_DEV_ADR = 4'd1;
  localparam logic [3:0] S_DEV_ACK = 4'd2;
  localparam logic [3:0] S_MEM_ADR = 4'd3;
  localparam logic [3:0] S_MEM_ACK = 4'd4;
  localparam logic [3:0] S_WR_DATA = 4'd5;
  localparam logic [3:0] S_WR_ACK  = 4'd6;
  localparam logic [3:0] S_RD_DATA = 4'd7;
  localparam logic [3:0] S_RD_ACK  = 4'd8;

  // lane 0 = SCL, lane 1 = SDA
  logic [1:0] line_raw, line_f;
  assign line_raw = {sda_i, scl_i};

  for (genvar g = 0; g < 2; g++) begin : g_filt
    i2c_slave_filt #(.FILTER(FILTER)) u_filt (
      .clk    (clk),
      .nReset (nReset),
      .din    (line_raw[g]),
      .dout   (line_f[g])
    );
  end

  logic scl_f, sda_f, scl_d, sda_d;
  assign scl_f = line_f[0];
  assign sda_f = line_f[1];

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  // SCL must be high on both sides of the SDA edge: when both filters drop
  // in the same clk (e.g. right after reset) that is not a START.
  logic scl_rise, scl_fall, start_c, stop_c;
  assign scl_rise = scl_f & ~scl_d;
  assign scl_fall = ~scl_f & scl_d;
  assign start_c  = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_c   = scl_f & scl_d & ~sda_d & sda_f;

  logic [3:0]        state;
  logic [2:0]        bit_cnt;
  logic              byte_done;   // 8 bits shifted, act on the following fall
  logic [7:0]        shreg;
  logic [7:0]        rd_byte;
  logic              rw;
  logic              ack_n;
  logic [MEM_AW-1:0] ptr;
  logic [7:0]        mem [MEM_DEPTH];

  assign sda_o    = 1'b0;
  assign host_dat = mem[host_adr];

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      byte_done <= 1'b0;
      shreg     <= '0;
      rd_byte   <= '0;
      rw        <= 1'b0;
      ack_n     <= 1'b1;
      ptr       <= '0;
      sda_oen   <= 1'b1;
      wr_stb    <= 1'b0;
      wr_adr    <= '0;
      wr_dat    <= '0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_stb    <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      if (start_c) begin
        // pointer deliberately kept for read-after-address-write
        state     <= S_DEV_ADR;
        bit_cnt   <= '0;
        byte_done <= 1'b0;
        sda_oen   <= 1'b1;
        start_det <= 1'b1;
        busy      <= 1'b1;
      end else if (stop_c) begin
        state    <= S_IDLE;
        sda_oen  <= 1'b1;
        stop_det <= 1'b1;
        busy     <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          S_DEV_ADR, S_MEM_ADR, S_WR_DATA, S_RD_DATA: begin
            shreg   <= {shreg[6:0], sda_f};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) byte_done <= 1'b1;
          end
          S_RD_ACK: ack_n <= sda_f;
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          S_DEV_ADR: if (byte_done) begin
            byte_done <= 1'b0;
            if (shreg[7:1] == I2C_ADR) begin
              state   <= S_DEV_ACK;
              sda_oen <= 1'b0;
              rw      <= shreg[0];
            end else begin
              state   <= S_IDLE;
            end
          end
          S_DEV_ACK: begin
            bit_cnt <= '0;
            if (rw) begin
              state   <= S_RD_DATA;
              rd_byte <= mem[ptr];
              sda_oen <= mem[ptr][7];
            end else begin
              state   <= S_MEM_ADR;
              sda_oen <= 1'b1;
            end
          end
          S_MEM_ADR: if (byte_done) begin
            byte_done <= 1'b0;
            if ({1'b0, shreg} < 9'(MEM_DEPTH)) begin
              ptr     <= shreg[MEM_AW-1:0];
              sda_oen <= 1'b0;
              state   <= S_MEM_ACK;
            end else begin
              state   <= S_IDLE;
            end
          end
          S_MEM_ACK, S_WR_ACK: begin
            state   <= S_WR_DATA;
            sda_oen <= 1'b1;
            bit_cnt <= '0;
          end
          S_WR_DATA: if (byte_done) begin
            byte_done <= 1'b0;
            mem[ptr]  <= shreg;
            wr_stb    <= 1'b1;
            wr_adr    <= ptr;
            wr_dat    <= shreg;
            sda_oen   <= 1'b0;
            ptr       <= ptr + MEM_AW'(1);
            state     <= S_WR_ACK;
          end
          S_RD_DATA: begin
            if (byte_done) begin
              byte_done <= 1'b0;
              sda_oen   <= 1'b1;
              ptr       <= ptr + MEM_AW'(1);
              state     <= S_RD_ACK;
            end else begin
              // bit 7 went out on entry; bit_cnt counts rises seen so far
              sda_oen <= rd_byte[3'd7 - bit_cnt];
            end
          end
          S_RD_ACK: begin
            if (!ack_n) begin
              state   <= S_RD_DATA;
              rd_byte <= mem[ptr];
              sda_oen <= mem[ptr][7];
              bit_cnt <= '0;
            end else begin
              state   <= S_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: doc/i2c_slave_core.md
Name: i2c_slave_core

Overview:
Synthesizable, parametrised I2C slave with an internal register file. It replaces the behavioural slave model in benches and can also be used as a target inside the design. SCL/SDA are oversampled on the system clock, then synchronised and glitch-filtered. Transactions use a 7-bit device address, followed by one memory-address byte and auto-incrementing data bytes. Unlike the model, it adds a configurable depth, wrap-around addressing, a glitch filter, a host read-back port and event strobes.

Parameters:
I2C_ADR, 7'h10, 7-bit device address matched against the first byte after START.
MEM_AW, 4, memory address width. Depth MEM_DEPTH = 2**MEM_AW, with 1 <= MEM_AW <= 8.
FILTER, 3, number of consecutive identical synchronised samples required before filtered SCL/SDA change. Range 1..15.

Ports:
clk  in  1  system clock. Must run at >= 16x the SCL frequency.
nReset  in  1  asynchronous active-low reset.
scl_i  in  1  SCL line input.
sda_i  in  1  SDA line input.
sda_o  out  1  SDA output data, constant 0.
sda_oen  out  1  SDA output enable, active-low. 0 drives the line low, 1 releases it.
host_adr  in  MEM_AW  host-side read address.
host_dat  out  8  combinational mem[host_adr].
wr_stb  out  1  one-clk pulse when a byte is written to memory from I2C.
wr_adr  out  MEM_AW  address of the last I2C write. Valid while wr_stb=1.
wr_dat  out  8  data of the last I2C write. Valid while wr_stb=1.
start_det  out  1  one-clk pulse on START or repeated START.
stop_det  out  1  one-clk pulse on STOP.
busy  out  1  high from START until STOP.

Behaviour:
- Reset values:
  - sda_oen=1; wr_stb, start_det, stop_det, busy = 0; wr_adr=0; wr_dat=0.
  - All memory bytes = 8'h00; pointer=0; state=IDLE.
  - Filtered SCL and SDA = 1.
- Input path:
  - 2-FF synchroniser, then the FILTER stability counter.
  - Input-to-filtered latency = 2+FILTER clks.
  - Pulses shorter than FILTER clks are ignored.
- Events, evaluated on filtered signals:
  - SCL rise samples a bit; SCL fall advances drive/state.
  - START = SDA fall while SCL=1. STOP = SDA rise while SCL=1.
- State encoding (one-hot or binary), states: IDLE, DEV_ADR, DEV_ACK, MEM_ADR, MEM_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
- START in any state:
  - Go to DEV_ADR, bit count=0, sda_oen=1, pulse start_det, busy=1.
  - Pointer is kept, so a repeated START supports read-after-address-write.
- STOP in any state: go to IDLE, sda_oen=1, pulse stop_det, busy=0.
- START and STOP take priority over bit processing in the same clk.
- DEV_ADR: shift 8 bits MSB-first on SCL rises. On the SCL fall after bit 8:
  - If byte[7:1]==I2C_ADR: go to DEV_ACK with sda_oen=0, and latch rw=byte[0].
  - Otherwise go to IDLE and stay released until the next START.
- DEV_ACK, on the next SCL fall:
  - If rw=1: go to RD_DATA and drive mem[pointer][7] (sda_oen = bit value).
  - If rw=0: go to MEM_ADR with the line released.
- MEM_ADR, after 8 bits:
  - If byte < MEM_DEPTH: pointer=byte[MEM_AW-1:0], ACK, go to MEM_ACK.
  - Otherwise: NACK (oen stays 1), pointer unchanged, go to IDLE.
- MEM_ACK, on SCL fall: release the line, go to WR_DATA.
- WR_DATA, after 8 bits:
  - mem[pointer] <= byte.
  - wr_stb pulses with wr_adr=pointer and wr_dat=byte.
  - ACK, then pointer = (pointer+1) mod MEM_DEPTH, wrapping from MEM_DEPTH-1 to 0.
  - Go to WR_ACK.
- WR_ACK, on SCL fall: release the line, go to WR_DATA.
- RD_DATA:
  - Drive bit 7-n on successive SCL falls. The read byte is latched from mem[pointer] at entry.
  - After the 8th bit's SCL fall: release the line, pointer increments with wrap, go to RD_ACK.
- RD_ACK: sample the master's ACK on SCL rise. On SCL fall:
  - ACK (0): go to RD_DATA with the next byte.
  - NACK (1): go to IDLE with the line released.
- Bit counter wraps 7->0 per byte. Exactly 9 SCL pulses per byte including ACK.
- sda_oen changes only in the clk after a filtered SCL fall. Never while filtered SCL=1, except release on START/STOP.
- Asynchronous reset mid-transfer:
  - Line released immediately; memory cleared.
  - Slave ignores the bus until the next START.
- host_dat is combinational. A host read of the address being written in the same clk returns the old value.

Test Plan:
1. Write: START, 0x20, 0x02, 0xA5, 0x5A, 0x3C, STOP.
   -> ACK on all 5 bytes; mem[2..4]=A5,5A,3C; 3 wr_stb pulses; wr_adr=2,3,4; stop_det=1; busy=0.
2. Read: START, 0x20, 0x02, repeated START, 0x21, read 3 bytes (ACK, ACK, NACK), STOP.
   -> SDA returns A5,5A,3C; start_det pulses twice.
3. Wrong device: START, 0x22 -> no ACK (sda_oen=1 throughout), memory unchanged, slave ignores the bus until STOP/START.
4. Range and wrap, MEM_AW=4:
   - Memory address 0x10 -> NACK.
   - Memory address 0x0F, write 0x11, 0x22 -> mem[15]=0x11, mem[0]=0x22.
5. Glitch, FILTER=3:
   - 2-clk low pulse on SCL mid-byte -> no bit shifted, no state change.
   - 4-clk pulse -> counted as a clock.
6. Reset: assert nReset during the DEV_ACK low drive -> sda_oen=1 within 0 clks, mem all 0; a following full write transaction succeeds.
